// File: rtl/theta_extract.sv
// Hyperspherical angle extraction: folds a vector through successive CORDIC vectoring
// steps, collecting one angle per step and the final magnitude as the norm.
`timescale 1ns/1ps

module theta_extract #(
    parameter int DATA_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 16,
    parameter int N_DIM       = 7,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [DATA_WIDTH*N_DIM-1:0]        w_in_flat,
    output logic                               cordic_vec_en,
    output logic [DATA_WIDTH-1:0]              cordic_vec_xin,
    output logic [DATA_WIDTH-1:0]              cordic_vec_yin,
    output logic                               cordic_vec_angle_calc_en,
    input  logic                               cordic_vec_opvld,
    input  logic [DATA_WIDTH-1:0]              cordic_vec_xout,
    input  logic [ANGLE_WIDTH-1:0]             vec_angle_out,
    output logic [ANGLE_WIDTH*(N_DIM-1)-1:0]   thetas_out_flat,
    output logic [DATA_WIDTH-1:0]              norm_out,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);

    localparam int N_TH  = N_DIM - 1;
    localparam int IDX_W = (N_DIM > 2) ? $clog2(N_DIM) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIM - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef logic [DATA_WIDTH-1:0]  data_t;
    typedef logic [ANGLE_WIDTH-1:0] angle_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

    state_t            state_q, state_d;
    data_t             w_in [N_DIM];
    data_t             w_q  [N_DIM];
    data_t             w_d  [N_DIM];
    angle_t            th_q [N_TH];
    angle_t            th_d [N_TH];
    data_t             acc_q, acc_d;
    data_t             xin_q, xin_d;
    data_t             yin_q, yin_d;
    data_t             norm_q, norm_d;
    logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt, th_idx;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              zero_q, zero_d;
    logic              done_q, done_d;
    logic              vec_en_q, busy_q;
    logic              w_is_zero;

    always_comb begin
        for (int i = 0; i < N_DIM; i++) begin
            w_in[i] = w_in_flat[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_is_zero = ~|w_in_flat;
    assign idx_nxt   = idx_q + 1'b1;
    assign th_idx    = idx_q - 1'b1;

    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        w_d     = w_q;
        th_d    = th_q;
        acc_d   = acc_q;
        xin_d   = xin_q;
        yin_d   = yin_q;
        norm_d  = norm_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    w_d    = w_in;
                    acc_d  = w_in[0];
                    idx_d  = IDX_W'(1);
                    tmo_d  = '0;
                    err_d  = 1'b0;
                    zero_d = w_is_zero;
                    if (w_is_zero) begin
                        for (int k = 0; k < N_TH; k++) th_d[k] = '0;
                        norm_d  = '0;
                        state_d = S_FINISH;
                    end else begin
                        xin_d   = w_in[0];
                        yin_d   = w_in[1];
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (cordic_vec_opvld) begin
                    th_d[th_idx] = vec_angle_out;
                    acc_d        = cordic_vec_xout;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        // Next operands are loaded here so they are stable throughout ISSUE.
                        idx_d   = idx_nxt;
                        xin_d   = cordic_vec_xout;
                        yin_d   = w_q[idx_nxt];
                        state_d = S_ISSUE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_FINISH: begin
                done_d  = 1'b1;
                norm_d  = (zero_q || err_q) ? data_t'(0) : acc_q;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            // NOTE: the vector and angle arrays are plain flops, cleared so no X ever reaches an output.
            for (int i = 0; i < N_DIM; i++) w_q[i] <= '0;
            for (int k = 0; k < N_TH; k++) th_q[k] <= '0;
            acc_q    <= '0;
            xin_q    <= '0;
            yin_q    <= '0;
            norm_q   <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            vec_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            w_q      <= w_d;
            th_q     <= th_d;
            acc_q    <= acc_d;
            xin_q    <= xin_d;
            yin_q    <= yin_d;
            norm_q   <= norm_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            vec_en_q <= (state_d == S_ISSUE);
            busy_q   <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        thetas_out_flat = '0;
        for (int k = 0; k < N_TH; k++) begin
            thetas_out_flat[k*ANGLE_WIDTH +: ANGLE_WIDTH] = th_q[k];
        end
    end

    assign cordic_vec_en            = vec_en_q;
    assign cordic_vec_xin           = xin_q;
    assign cordic_vec_yin           = yin_q;
    assign cordic_vec_angle_calc_en = 1'b1;
    assign norm_out                 = norm_q;
    assign busy                     = busy_q;
    assign done                     = done_q;
    assign err                      = err_q;

endmodule
